// File: rtl/cmprs_afi_aw_issue.sv
// Compressor AFI write-address issuer.
// Turns arbiter burst requests for 4 channels into AXI AW bursts, clipping
// each burst at the circular-buffer end and at 4KB boundaries, and advances
// the per-channel 32-byte chunk pointers on every AW handshake.
module cmprs_afi_aw_issue #(
   parameter int AFI_ADDR_W = 32
) (
   input  logic                  hclk,
   input  logic                  hrst,
   input  logic                  en,
   input  logic [26:0]           sa_len_di,
   input  logic [2:0]            sa_len_wa,
   input  logic                  sa_len_we,
   input  logic [3:0]            reset_pointers,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_chn,
   input  logic [2:0]            req_chunks,
   input  logic                  req_eof,
   output logic                  afi_awvalid,
   input  logic                  afi_awready,
   output logic [AFI_ADDR_W-1:0] afi_awaddr,
   output logic [5:0]            afi_awid,
   output logic [3:0]            afi_awlen,
   output logic [1:0]            afi_awsize,
   output logic [1:0]            afi_awburst,
   output logic                  burst_done,
   output logic [1:0]            burst_chn,
   output logic [2:0]            burst_chunks,
   output logic [2:0]            burst_rem,
   input  logic [1:0]            chunk_ptr_ra,
   output logic [26:0]           chunk_ptr_rd
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_AW, S_RST} state_t;

   state_t      state, state_nxt;

   logic        en_d;
   logic        en_rise;
   logic [3:0]  pend;
   logic [3:0]  pend_clr;
   logic [1:0]  low_chn;
   logic [1:0]  rst_chn;
   logic        accept;
   logic        aw_hs;

   logic [26:0] sa_len [8];
   logic [26:0] ptr [4];

   // request fields captured at accept
   logic [1:0]  r_chn;
   logic [2:0]  r_chunks;
   logic        r_eof;

   // buffer state captured in RD
   logic [26:0] l_ptr, l_start, l_len;

   // CALC combinational results
   logic [26:0] sum_c, rem_buf_c, nsum_c, nptr_c;
   logic [7:0]  to4k_c;
   logic [2:0]  n_c;
   logic        eof_c;

   // results carried into AW
   logic [2:0]  n_r;
   logic [26:0] nptr_r;

   assign en_rise      = en && !en_d;
   assign accept       = req_valid && req_ready;
   assign aw_hs        = (state == S_AW) && afi_awready;
   assign afi_awsize   = 2'b11;
   assign afi_awburst  = 2'b01;
   assign chunk_ptr_rd = ptr[chunk_ptr_ra];

   // state register
   always_ff @(posedge hclk) begin
      if (hrst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // next state: pending pointer resets win over new requests
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (pend != 4'd0) state_nxt = S_RST;
            else if (accept)  state_nxt = S_RD;
         end
         S_RD:   state_nxt = S_CALC;
         S_CALC: state_nxt = S_AW;
         S_AW:   if (afi_awready) state_nxt = S_IDLE;
         S_RST:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs decoded from state; a rising en blocks accepts until its resets land
   always_comb begin
      req_ready   = (state == S_IDLE) && en && !en_rise && (pend == 4'd0);
      afi_awvalid = (state == S_AW);
   end

   // lowest pending channel is reset first
   always_comb begin
      low_chn = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (pend[i]) low_chn = 2'(i);
   end

   // one-hot clear of the channel being reset this cycle
   always_comb begin
      pend_clr = 4'd0;
      if (state == S_RST) pend_clr[rst_chn] = 1'b1;
   end

   // pending reset mask: new requests OR in, served ones drop out
   always_ff @(posedge hclk) begin
      if (hrst) begin
         en_d    <= 1'b0;
         pend    <= 4'd0;
         rst_chn <= 2'd0;
      end else begin
         en_d <= en;
         pend <= (pend & ~pend_clr) | reset_pointers | {4{en_rise}};
         if (state == S_IDLE && pend != 4'd0) rst_chn <= low_chn;
      end
   end

   // start/length RAM, not reset
   always_ff @(posedge hclk) begin
      if (sa_len_we) sa_len[sa_len_wa] <= sa_len_di;
   end

   // chunk pointers: advanced on AW handshake, cleared in RST
   always_ff @(posedge hclk) begin
      if (hrst) begin
         for (int i = 0; i < 4; i++) ptr[i] <= 27'd0;
      end else if (aw_hs) begin
         ptr[r_chn] <= nptr_r;
      end else if (state == S_RST) begin
         ptr[rst_chn] <= 27'd0;
      end
   end

   // capture request on accept, buffer state in RD
   always_ff @(posedge hclk) begin
      if (hrst) begin
         r_chn    <= 2'd0;
         r_chunks <= 3'd0;
         r_eof    <= 1'b0;
         l_ptr    <= 27'd0;
         l_start  <= 27'd0;
         l_len    <= 27'd0;
      end else begin
         if (state == S_IDLE && pend == 4'd0 && accept) begin
            r_chn    <= req_chn;
            r_chunks <= req_chunks;
            r_eof    <= req_eof;
         end
         if (state == S_RD) begin
            l_ptr   <= ptr[r_chn];
            l_start <= sa_len[{1'b0, r_chn}];
            l_len   <= sa_len[{1'b1, r_chn}];
         end
      end
   end

   // burst size: min(requested, left in buffer, left in 4KB page)
   always_comb begin
      sum_c     = l_start + l_ptr;
      rem_buf_c = l_len - l_ptr;
      to4k_c    = 8'd128 - {1'b0, sum_c[6:0]};
      n_c       = r_chunks;
      if (rem_buf_c < {24'd0, n_c}) n_c = rem_buf_c[2:0];
      if (to4k_c < {5'd0, n_c})     n_c = to4k_c[2:0];
      nsum_c    = l_ptr + {24'd0, n_c};
      nptr_c    = (nsum_c == l_len) ? 27'd0 : nsum_c;
      eof_c     = r_eof && (n_c == r_chunks);
   end

   // AW payload registered at end of CALC, held until handshake
   always_ff @(posedge hclk) begin
      if (hrst) begin
         afi_awaddr <= '0;
         afi_awid   <= 6'd0;
         afi_awlen  <= 4'd0;
         n_r        <= 3'd0;
         nptr_r     <= 27'd0;
      end else if (state == S_CALC) begin
         afi_awaddr <= AFI_ADDR_W'({sum_c, 5'b0});
         afi_awid   <= {1'b0, 2'(n_c - 3'd1), eof_c, r_chn};
         afi_awlen  <= {2'(n_c - 3'd1), 2'b11};
         n_r        <= n_c;
         nptr_r     <= nptr_c;
      end
   end

   // per-burst notification to the W data mover
   always_ff @(posedge hclk) begin
      if (hrst) begin
         burst_done   <= 1'b0;
         burst_chn    <= 2'd0;
         burst_chunks <= 3'd0;
         burst_rem    <= 3'd0;
      end else begin
         burst_done <= aw_hs;
         if (aw_hs) begin
            burst_chn    <= r_chn;
            burst_chunks <= n_r;
            burst_rem    <= r_chunks - n_r;
         end
      end
   end

endmodule
